// File: rtl/cam_write_bram_pkg.sv
// Shared definitions for the camera frame-buffer writer and the VGA reader:
// RGB565 field layout, default frame geometry and capture FSM encoding.
package cam_write_bram_pkg;

  localparam int IMG_W_DEF  = 320;
  localparam int IMG_H_DEF  = 240;
  localparam int ADDR_W_DEF = 17;

  // RGB565 word layout {R[4:0], G[5:0], B[4:0]}
  localparam int RGB_R_LSB = 11;
  localparam int RGB_R_W   = 5;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_G_W   = 6;
  localparam int RGB_B_LSB = 0;
  localparam int RGB_B_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VS_HI,
    ST_WAIT_VS_LO,
    ST_CAPTURE,
    ST_DONE
  } cap_state_e;

endpackage

// File: rtl/dvp_sync_edge.sv
// Brings the asynchronous DVP camera signals into the clk25 domain and
// produces registered byte-valid, line-end and vsync-level indications.
module dvp_sync_edge #(
  parameter bit VSYNC_ACTIVE = 1'b1,
  parameter bit HREF_ACTIVE  = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pclk_i,
  input  logic       vsync_i,
  input  logic       href_i,
  input  logic [7:0] data_i,
  output logic       byteValid_o,
  output logic       lineEnd_o,
  output logic       vsyncActive_o,
  output logic [7:0] data_o
);

  logic [2:0] pclkSync_q;
  logic [2:0] hrefSync_q;
  logic [1:0] vsyncSync_q;
  logic [7:0] dataS1_q;
  logic [7:0] dataS2_q;
  logic       byteValid_q;
  logic       lineEnd_q;
  logic       vsyncActive_q;
  logic [7:0] data_q;

  logic pclkRise;
  logic hrefNow;
  logic hrefPrev;

  assign pclkRise = pclkSync_q[1] & ~pclkSync_q[2];
  assign hrefNow  = (hrefSync_q[1] == HREF_ACTIVE);
  assign hrefPrev = (hrefSync_q[2] == HREF_ACTIVE);

  // A byte that coincides with the href fall still belongs to the closing line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pclkSync_q    <= '0;
      hrefSync_q    <= {3{~HREF_ACTIVE}};
      vsyncSync_q   <= {2{~VSYNC_ACTIVE}};
      dataS1_q      <= '0;
      dataS2_q      <= '0;
      byteValid_q   <= 1'b0;
      lineEnd_q     <= 1'b0;
      vsyncActive_q <= 1'b0;
      data_q        <= '0;
    end else begin
      pclkSync_q    <= {pclkSync_q[1:0], pclk_i};
      hrefSync_q    <= {hrefSync_q[1:0], href_i};
      vsyncSync_q   <= {vsyncSync_q[0], vsync_i};
      dataS1_q      <= data_i;
      dataS2_q      <= dataS1_q;
      byteValid_q   <= pclkRise & (hrefNow | hrefPrev);
      lineEnd_q     <= hrefPrev & ~hrefNow;
      vsyncActive_q <= (vsyncSync_q[1] == VSYNC_ACTIVE);
      data_q        <= dataS2_q;
    end
  end

  assign byteValid_o   = byteValid_q;
  assign lineEnd_o     = lineEnd_q;
  assign vsyncActive_o = vsyncActive_q;
  assign data_o        = data_q;

endmodule

// File: rtl/cam_write_bram.sv
// DVP RGB565 camera capture into a row-major BRAM frame buffer, cropped to
// IMG_W x IMG_H, one 16-bit pixel per word starting at address 0.
module cam_write_bram
  import cam_write_bram_pkg::*;
#(
  parameter int IMG_W        = IMG_W_DEF,
  parameter int IMG_H        = IMG_H_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter bit VSYNC_ACTIVE = 1'b1,
  parameter bit HREF_ACTIVE  = 1'b1
) (
  input  logic              clk25,
  input  logic              rst,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              capture_en,
  output logic [ADDR_W-1:0] frame_addr,
  output logic [15:0]       frame_data,
  output logic              frame_we,
  output logic              frame_done,
  output logic              busy
);

  localparam int COL_W  = $clog2(IMG_W + 1);
  localparam int ROW_W  = $clog2(IMG_H + 1);
  localparam int BASE_W = ADDR_W + 1;
  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(IMG_W);
  localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(IMG_H);
  localparam logic [BASE_W-1:0] LINE_STEP = BASE_W'(IMG_W);

  logic       byteValid;
  logic       lineEnd;
  logic       vsyncActive;
  logic [7:0] camByte;

  dvp_sync_edge #(
    .VSYNC_ACTIVE(VSYNC_ACTIVE),
    .HREF_ACTIVE (HREF_ACTIVE)
  ) u_sync (
    .clk_i        (clk25),
    .rst_i        (rst),
    .pclk_i       (cam_pclk),
    .vsync_i      (cam_vsync),
    .href_i       (cam_href),
    .data_i       (cam_data),
    .byteValid_o  (byteValid),
    .lineEnd_o    (lineEnd),
    .vsyncActive_o(vsyncActive),
    .data_o       (camByte)
  );

  cap_state_e        state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [BASE_W-1:0] lineBase_q, lineBase_d;
  logic              phase_q, phase_d;
  logic [7:0]        hiByte_q, hiByte_d;
  logic              pixValid_q, pixValid_d;
  logic [ADDR_W-1:0] pixAddr_q, pixAddr_d;
  logic [15:0]       pixData_q, pixData_d;
  logic              frameWe_q;
  logic [ADDR_W-1:0] frameAddr_q;
  logic [15:0]       frameData_q;

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      lineBase_q  <= '0;
      phase_q     <= 1'b0;
      hiByte_q    <= '0;
      pixValid_q  <= 1'b0;
      pixAddr_q   <= '0;
      pixData_q   <= '0;
      frameWe_q   <= 1'b0;
      frameAddr_q <= '0;
      frameData_q <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      lineBase_q <= lineBase_d;
      phase_q    <= phase_d;
      hiByte_q   <= hiByte_d;
      pixValid_q <= pixValid_d;
      pixAddr_q  <= pixAddr_d;
      pixData_q  <= pixData_d;
      frameWe_q  <= pixValid_q;
      if (pixValid_q) begin
        frameAddr_q <= pixAddr_q;
        frameData_q <= pixData_q;
      end
    end
  end

  // Line end is applied after the byte so a coincident last byte is kept first.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    lineBase_d = lineBase_q;
    phase_d    = phase_q;
    hiByte_d   = hiByte_q;
    pixValid_d = 1'b0;
    pixAddr_d  = pixAddr_q;
    pixData_d  = pixData_q;
    unique case (state_q)
      ST_IDLE: begin
        if (capture_en) state_d = ST_WAIT_VS_HI;
      end
      ST_WAIT_VS_HI: begin
        if (!capture_en)      state_d = ST_IDLE;
        else if (vsyncActive) state_d = ST_WAIT_VS_LO;
      end
      ST_WAIT_VS_LO: begin
        if (!capture_en) begin
          state_d = ST_IDLE;
        end else if (!vsyncActive) begin
          state_d    = ST_CAPTURE;
          col_d      = '0;
          row_d      = '0;
          lineBase_d = '0;
          phase_d    = 1'b0;
        end
      end
      ST_CAPTURE: begin
        if (byteValid) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            hiByte_d = camByte;
          end else if (col_q < COL_MAX && row_q < ROW_MAX) begin
            pixValid_d = 1'b1;
            pixAddr_d  = ADDR_W'(lineBase_q + BASE_W'(col_q));
            pixData_d  = {hiByte_q, camByte};
            col_d      = col_q + 1'b1;
          end
        end
        if (lineEnd) begin
          col_d   = '0;
          phase_d = 1'b0;
          if (row_q < ROW_MAX) begin
            row_d      = row_q + 1'b1;
            lineBase_d = lineBase_q + LINE_STEP;
          end
        end
        if (vsyncActive) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = capture_en ? ST_WAIT_VS_LO : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign frame_we   = frameWe_q;
  assign frame_addr = frameAddr_q;
  assign frame_data = frameData_q;
  assign frame_done = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cam_write_bram.sv
// Directed bench for cam_write_bram on a reduced 16x12 frame: a camera
// driver that also builds the expected frame buffer, and a BRAM write monitor.
module tb_cam_write_bram;

  localparam int W    = 16;
  localparam int H    = 12;
  localparam int AW   = 8;
  localparam int NPIX = W * H;

  logic          clk25 = 1'b0;
  logic          rst;
  logic          cam_pclk;
  logic          cam_vsync;
  logic          cam_href;
  logic [7:0]    cam_data;
  logic          capture_en;
  logic [AW-1:0] frame_addr;
  logic [15:0]   frame_data;
  logic          frame_we;
  logic          frame_done;
  logic          busy;

  cam_write_bram #(
    .IMG_W(W),
    .IMG_H(H),
    .ADDR_W(AW),
    .VSYNC_ACTIVE(1'b1),
    .HREF_ACTIVE(1'b1)
  ) dut (
    .clk25     (clk25),
    .rst       (rst),
    .cam_pclk  (cam_pclk),
    .cam_vsync (cam_vsync),
    .cam_href  (cam_href),
    .cam_data  (cam_data),
    .capture_en(capture_en),
    .frame_addr(frame_addr),
    .frame_data(frame_data),
    .frame_we  (frame_we),
    .frame_done(frame_done),
    .busy      (busy)
  );

  always #20 clk25 = ~clk25;

  int checkCount = 0;
  int errorCount = 0;
  int cyc = 0;

  always @(posedge clk25) cyc++;

  // BRAM write monitor; a word belongs to the current frame when its epoch matches.
  int          epoch = 0;
  int          wrEpoch [256];
  logic [15:0] mem [256];
  int          weTotal = 0;
  int          doneTotal = 0;
  int          oobTotal = 0;
  int          firstWeEpoch = 0;
  int          firstWeCyc = 0;
  int          firstWeAddr = 0;

  always @(negedge clk25) begin
    if (frame_we) begin
      if (int'(frame_addr) >= NPIX) oobTotal++;
      else begin
        wrEpoch[frame_addr] = epoch;
        mem[frame_addr]     = frame_data;
      end
      weTotal++;
      if (firstWeEpoch != epoch) begin
        firstWeEpoch = epoch;
        firstWeCyc   = cyc;
        firstWeAddr  = int'(frame_addr);
      end
    end
    if (frame_done) doneTotal++;
  end

  bit          expWritten [256];
  logic [15:0] expData [256];
  int          weBase, doneBase, oobBase;
  int          latRise;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] pixVal(input int seed, input int r, input int c);
    return 16'((seed << 12) | (r << 6) | c);
  endfunction

  // One camera byte: data/href change while pclk is low, pclk high for 2 cycles.
  task automatic applyStimulus(input logic [7:0] b, input logic href, output int riseCyc);
    @(negedge clk25);
    cam_pclk = 1'b0;
    cam_data = b;
    cam_href = href;
    @(negedge clk25);
    @(negedge clk25);
    cam_pclk = 1'b1;
    riseCyc  = cyc + 1;
    @(negedge clk25);
  endtask

  task automatic blankBytes(input int n);
    int rc;
    for (int i = 0; i < n; i++) applyStimulus(8'h5A, 1'b0, rc);
  endtask

  task automatic newFrameModel();
    epoch++;
    for (int a = 0; a < 256; a++) begin
      expWritten[a] = 1'b0;
      expData[a]    = '0;
    end
    weBase   = weTotal;
    doneBase = doneTotal;
    oobBase  = oobTotal;
  endtask

  task automatic sendLine(input int nBytes, input int r, input int seed, input bit endLine);
    int          rc;
    int          c;
    logic [15:0] v;
    for (int k = 0; k < nBytes; k++) begin
      c = k / 2;
      v = pixVal(seed, r, c);
      applyStimulus((k % 2 == 0) ? v[15:8] : v[7:0], 1'b1, rc);
      if (k == 1 && r == 0) latRise = rc;
      if (k % 2 == 1 && c < W && r < H) begin
        expWritten[r*W + c] = 1'b1;
        expData[r*W + c]    = v;
      end
    end
    if (endLine) begin
      applyStimulus(8'hEE, 1'b0, rc);
      applyStimulus(8'hEE, 1'b0, rc);
    end
  endtask

  task automatic frameStart();
    @(negedge clk25);
    cam_vsync = 1'b1;
    blankBytes(3);
    cam_vsync = 1'b0;
    blankBytes(3);
  endtask

  task automatic frameEnd();
    @(negedge clk25);
    cam_vsync = 1'b1;
    blankBytes(4);
  endtask

  task automatic sendFrame(input int nLines, input int nBytes, input int seed);
    frameStart();
    for (int r = 0; r < nLines; r++) sendLine(nBytes, r, seed, 1'b1);
    frameEnd();
  endtask

  task automatic checkFrame(input string tag, input int expWrites, input int expDone);
    logic [31:0] obs, exp;
    checkOutput($sformatf("%s writes", tag), 32'(weTotal - weBase), 32'(expWrites));
    checkOutput($sformatf("%s frame_done", tag), 32'(doneTotal - doneBase), 32'(expDone));
    checkOutput($sformatf("%s out-of-range", tag), 32'(oobTotal - oobBase), 32'd0);
    for (int a = 0; a < NPIX; a++) begin
      obs = (wrEpoch[a] == epoch) ? {16'h0001, mem[a]} : 32'h0;
      exp = expWritten[a] ? {16'h0001, expData[a]} : 32'h0;
      checkOutput($sformatf("%s pix%0d", tag, a), obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput($sformatf("%s frame_we", tag), 32'(frame_we), 32'd0);
    checkOutput($sformatf("%s frame_done", tag), 32'(frame_done), 32'd0);
    checkOutput($sformatf("%s busy", tag), 32'(busy), 32'd0);
    checkOutput($sformatf("%s frame_addr", tag), 32'(frame_addr), 32'd0);
    checkOutput($sformatf("%s frame_data", tag), 32'(frame_data), 32'd0);
  endtask

  initial begin
    int rc;
    rst        = 1'b1;
    cam_pclk   = 1'b0;
    cam_vsync  = 1'b0;
    cam_href   = 1'b0;
    cam_data   = 8'h00;
    capture_en = 1'b0;
    repeat (3) @(negedge clk25);
    checkAllZero("reset");
    rst = 1'b0;

    // Test 1: reset in the middle of a captured frame aborts everything.
    $display("[TB] test 1: reset mid-run");
    capture_en = 1'b1;
    newFrameModel();
    frameStart();
    sendLine(32, 0, 1, 1'b1);
    sendLine(20, 1, 1, 1'b0);
    @(negedge clk25);
    rst        = 1'b1;
    capture_en = 1'b0;
    cam_href   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk25);
      checkAllZero($sformatf("t1 rst cyc%0d", i));
    end
    rst = 1'b0;
    newFrameModel();
    for (int i = 0; i < H; i++) expWritten[i] = 1'b0;
    frameStart();
    for (int r = 0; r < H; r++) begin
      sendLine(32, r, 2, 1'b1);
    end
    frameEnd();
    for (int a = 0; a < 256; a++) expWritten[a] = 1'b0;
    checkFrame("t1 idle", 0, 0);
    checkOutput("t1 busy idle", 32'(busy), 32'd0);

    // Test 2: full frame, exact fit, and first-pixel latency.
    $display("[TB] test 2: full frame");
    capture_en = 1'b1;
    newFrameModel();
    sendFrame(H, 2*W, 3);
    checkFrame("t2", 192, 1);
    checkOutput("t2 latency", 32'(firstWeCyc - latRise), 32'd4);
    checkOutput("t2 first addr", 32'(firstWeAddr), 32'd0);

    // Test 3: oversized frame 14 lines x 40 bytes is cropped.
    $display("[TB] test 3: oversized frame");
    newFrameModel();
    sendFrame(H + 2, 2*W + 8, 5);
    checkFrame("t3", 192, 1);

    // Test 4: odd-length and short lines; pixel at W comes from {byte0,byte1}.
    $display("[TB] test 4: odd and short lines");
    newFrameModel();
    frameStart();
    sendLine(2*W + 1, 0, 6, 1'b1);
    sendLine(2, 1, 6, 1'b1);
    sendLine(7, 2, 6, 1'b1);
    frameEnd();
    checkFrame("t4", 20, 1);
    checkOutput("t4 addr W", 32'(mem[W]), 32'(pixVal(6, 1, 0)));

    // Test 5: vsync after 5 lines plus a partial line still high, then a full frame.
    $display("[TB] test 5: short frame");
    newFrameModel();
    frameStart();
    for (int r = 0; r < 5; r++) sendLine(2*W, r, 7, 1'b1);
    sendLine(10, 5, 7, 1'b0);
    @(negedge clk25);
    cam_vsync = 1'b1;
    repeat (12) @(negedge clk25);
    cam_href = 1'b0;
    blankBytes(4);
    checkFrame("t5 short", 85, 1);
    newFrameModel();
    sendFrame(H, 2*W, 8);
    checkFrame("t5 next", 192, 1);
    checkOutput("t5 next first addr", 32'(firstWeAddr), 32'd0);

    // Test 6: capture_en drops mid-frame; the frame completes, then idle.
    $display("[TB] test 6: capture_en drop");
    newFrameModel();
    frameStart();
    for (int r = 0; r < H; r++) begin
      if (r == 3) capture_en = 1'b0;
      sendLine(2*W, r, 9, 1'b1);
    end
    frameEnd();
    checkFrame("t6", 192, 1);
    checkOutput("t6 busy", 32'(busy), 32'd0);
    newFrameModel();
    sendFrame(H, 2*W, 10);
    for (int a = 0; a < 256; a++) expWritten[a] = 1'b0;
    checkFrame("t6 after", 0, 0);
    checkOutput("t6 busy after", 32'(busy), 32'd0);

    applyStimulus(8'h00, 1'b0, rc);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
